// File: rtl/lib_rtl_pkg.sv
// Shared definitions for the arithmetic RTL library: FSM state encoding and the
// parameter elaboration check used by the multiplier and accumulator blocks.
`ifndef LIB_RTL_PKG_SV
`define LIB_RTL_PKG_SV

`define LIB_RTL_ELAB_CHECK(label, cond, msg) \
  if (!(cond)) begin : label \
    $fatal(1, msg); \
  end

package lib_rtl_pkg;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } acc_state_e;

endpackage

`endif

// File: rtl/acc_54u.sv
// Streaming unsigned accumulator: sums LENGTH products per batch and presents
// one wrapped sum plus sticky carry-out flag per batch on a valid/ready output.
`include "lib_rtl_pkg.sv"

module acc_54u
  import lib_rtl_pkg::*;
#(
  parameter int LENGTH    = 8,
  parameter int IN_WIDTH  = 54,
  parameter int ACC_WIDTH = 64
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 ivalid,
  output logic                 oready,
  input  logic [IN_WIDTH-1:0]  datain,
  output logic                 ovalid,
  input  logic                 iready,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 overflow
);

  `LIB_RTL_ELAB_CHECK(g_chk_length, LENGTH >= 1, "acc_54u: LENGTH must be >= 1")
  `LIB_RTL_ELAB_CHECK(g_chk_width, ACC_WIDTH >= IN_WIDTH, "acc_54u: ACC_WIDTH must be >= IN_WIDTH")

  localparam int CW = $clog2(LENGTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(LENGTH - 1);

  acc_state_e r_state;
  acc_state_e w_state_nxt;

  logic [ACC_WIDTH-1:0] r_acc;
  logic [CW-1:0]        r_count;
  logic                 r_ovf;
  logic [ACC_WIDTH-1:0] r_result;
  logic                 r_overflow;

  logic                 w_oready;
  logic                 w_in_acc;
  logic                 w_out_acc;
  logic                 w_last;
  logic [ACC_WIDTH-1:0] w_ext;
  logic [ACC_WIDTH:0]   w_sum;

  assign w_in_acc  = ivalid && w_oready;
  assign w_out_acc = (r_state == ST_HOLD) && iready;
  assign w_last    = (r_count == LAST_IDX);
  assign w_ext     = ACC_WIDTH'(datain);
  assign w_sum     = {1'b0, r_acc} + {1'b0, w_ext};

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_oready    = 1'b1;
    case (r_state)
      ST_ACCUM: begin
        w_oready = 1'b1;
        if (w_in_acc && w_last) w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        w_oready = iready;
        // A last element taken while the old result drains keeps us in HOLD.
        if (w_in_acc && w_last) w_state_nxt = ST_HOLD;
        else if (w_out_acc)     w_state_nxt = ST_ACCUM;
      end
      default: begin
        w_state_nxt = ST_ACCUM;
      end
    endcase
  end

  // acc/count/ovf are always cleared on entering HOLD, so an element accepted
  // in HOLD takes the same path as the first element of a batch in ACCUM.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_acc      <= '0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_result   <= '0;
      r_overflow <= 1'b0;
    end else if (w_in_acc) begin
      if (w_last) begin
        r_result   <= w_sum[ACC_WIDTH-1:0];
        r_overflow <= r_ovf | w_sum[ACC_WIDTH];
        r_acc      <= '0;
        r_count    <= '0;
        r_ovf      <= 1'b0;
      end else begin
        r_acc      <= w_sum[ACC_WIDTH-1:0];
        r_count    <= r_count + CW'(1);
        r_ovf      <= r_ovf | w_sum[ACC_WIDTH];
      end
    end
  end

  assign oready   = w_oready;
  assign ovalid   = (r_state == ST_HOLD);
  assign result   = r_result;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_acc_54u.sv
// Directed bench for acc_54u: three instances cover LENGTH=4, a 54-bit
// overflow configuration with LENGTH=2, and the LENGTH=1 pass-through case.
`timescale 1ns/1ps

module tb_acc_54u;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // LENGTH=4, ACC_WIDTH=64
  logic        a_ivalid, a_iready, a_oready, a_ovalid, a_overflow;
  logic [53:0] a_datain;
  logic [63:0] a_result;
  // LENGTH=2, ACC_WIDTH=54
  logic        b_ivalid, b_iready, b_oready, b_ovalid, b_overflow;
  logic [53:0] b_datain;
  logic [53:0] b_result;
  // LENGTH=1, ACC_WIDTH=64
  logic        c_ivalid, c_iready, c_oready, c_ovalid, c_overflow;
  logic [53:0] c_datain;
  logic [63:0] c_result;

  acc_54u #(.LENGTH(4), .IN_WIDTH(54), .ACC_WIDTH(64)) u_dut_a (
    .clock(clk), .resetn(rst_n), .ivalid(a_ivalid), .oready(a_oready),
    .datain(a_datain), .ovalid(a_ovalid), .iready(a_iready),
    .result(a_result), .overflow(a_overflow)
  );

  acc_54u #(.LENGTH(2), .IN_WIDTH(54), .ACC_WIDTH(54)) u_dut_b (
    .clock(clk), .resetn(rst_n), .ivalid(b_ivalid), .oready(b_oready),
    .datain(b_datain), .ovalid(b_ovalid), .iready(b_iready),
    .result(b_result), .overflow(b_overflow)
  );

  acc_54u #(.LENGTH(1), .IN_WIDTH(54), .ACC_WIDTH(64)) u_dut_c (
    .clock(clk), .resetn(rst_n), .ivalid(c_ivalid), .oready(c_oready),
    .datain(c_datain), .ovalid(c_ovalid), .iready(c_iready),
    .result(c_result), .overflow(c_overflow)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed_a(input logic [53:0] d);
    a_ivalid = 1'b1;
    a_datain = d;
    tick();
    a_ivalid = 1'b0;
  endtask

  initial begin
    logic [53:0] vals [3];
    vals[0] = 54'd5; vals[1] = 54'd6; vals[2] = 54'd7;

    rst_n = 1'b0;
    a_ivalid = 1'b0; a_iready = 1'b1; a_datain = '0;
    b_ivalid = 1'b0; b_iready = 1'b1; b_datain = '0;
    c_ivalid = 1'b0; c_iready = 1'b1; c_datain = '0;
    tick();
    tick();
    check("rst_ovalid", 64'(a_ovalid), 64'd0);
    check("rst_result", a_result, 64'd0);
    check("rst_overflow", 64'(a_overflow), 64'd0);
    check("rst_oready", 64'(a_oready), 64'd1);
    rst_n = 1'b1;
    tick();

    // Basic batch 1..4 with iready high
    for (int k = 1; k <= 4; k++) begin
      feed_a(54'(k));
      if (k < 4) check("basic_ovalid_early", 64'(a_ovalid), 64'd0);
    end
    check("basic_ovalid", 64'(a_ovalid), 64'd1);
    check("basic_result", a_result, 64'd10);
    check("basic_overflow", 64'(a_overflow), 64'd0);
    tick();
    check("basic_ovalid_1cyc", 64'(a_ovalid), 64'd0);

    // Backpressure: result held, oready low, offered input ignored
    a_iready = 1'b0;
    for (int k = 1; k <= 4; k++) feed_a(54'(k));
    check("bp_ovalid", 64'(a_ovalid), 64'd1);
    a_ivalid = 1'b1;
    a_datain = 54'd100;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_oready", 64'(a_oready), 64'd0);
      tick();
      check("bp_ovalid_hold", 64'(a_ovalid), 64'd1);
      check("bp_result_hold", a_result, 64'd10);
    end

    // Simultaneous output accept and first input of next batch
    a_iready = 1'b1;
    a_datain = 54'd7;
    #1;
    check("sim_oready", 64'(a_oready), 64'd1);
    tick();
    check("sim_ovalid_drop", 64'(a_ovalid), 64'd0);
    for (int k = 0; k < 3; k++) begin
      a_datain = 54'd1;
      tick();
    end
    a_ivalid = 1'b0;
    check("sim_ovalid", 64'(a_ovalid), 64'd1);
    check("sim_result", a_result, 64'd10);
    tick();
    check("sim_ovalid_after", 64'(a_ovalid), 64'd0);

    // Reset mid-batch discards the partial sum
    feed_a(54'd9);
    feed_a(54'd9);
    rst_n = 1'b0;
    #1;
    check("mrst_ovalid", 64'(a_ovalid), 64'd0);
    tick();
    rst_n = 1'b1;
    check("mrst_result", a_result, 64'd0);
    for (int k = 0; k < 4; k++) begin
      check("mrst_ovalid_early", 64'(a_ovalid), 64'd0);
      feed_a(54'd1);
    end
    check("mrst_ovalid_done", 64'(a_ovalid), 64'd1);
    check("mrst_result", a_result, 64'd4);
    tick();

    // Overflow at ACC_WIDTH=54, LENGTH=2, then a clean batch back to back
    b_ivalid = 1'b1;
    b_datain = '1;
    tick();
    b_datain = 54'd2;
    tick();
    check("ovf_ovalid", 64'(b_ovalid), 64'd1);
    check("ovf_result", 64'(b_result), 64'd1);
    check("ovf_overflow", 64'(b_overflow), 64'd1);
    b_datain = 54'd1;
    tick();
    check("ovf_ovalid_mid", 64'(b_ovalid), 64'd0);
    tick();
    b_ivalid = 1'b0;
    check("ovf2_ovalid", 64'(b_ovalid), 64'd1);
    check("ovf2_result", 64'(b_result), 64'd2);
    check("ovf2_overflow", 64'(b_overflow), 64'd0);
    tick();

    // LENGTH=1: each input appears as a result one cycle later
    c_ivalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      c_datain = vals[k];
      tick();
      check("len1_ovalid", 64'(c_ovalid), 64'd1);
      check("len1_result", c_result, 64'(vals[k]));
    end
    c_ivalid = 1'b0;
    tick();
    check("len1_ovalid_end", 64'(c_ovalid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
